registers_tx_block: RTL and testbench
=====================================

REGISTERS_TX_BLOCK -- requirements
Module: registers_tx_block

Interface
REQ-001 SHALL have parameter REG_ADDR_WIDTH, default 5, width of the register bus address.
REQ-002 SHALL have parameter REG_DATA_WIDTH, default 16, width of the register bus data.
REQ-003 SHALL have parameter TX_DATA_WIDTH, default 8, width of the tx simple-interface byte.
REQ-004 SHALL have parameter NUM_REGS, default 16, number of shadowed addresses (0..NUM_REGS-1); power of two, at most 2^REG_ADDR_WIDTH.
REQ-005 SHALL have one clock and a synchronous, active-high reset, with ports named as in the codebase:
- clk  input  1  sole clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
REQ-006 register_addr  input  REG_ADDR_WIDTH  register bus address.
REQ-007 register_data  input  REG_DATA_WIDTH  register bus data.
REQ-008 register_rdy  input  1  one-cycle write strobe on the register bus.
REQ-009 rqst_readback  input  1  one-cycle request to dump the shadow table.
REQ-010 tx_data  output  TX_DATA_WIDTH  byte offered to the tx arbiter.
REQ-011 tx_rdy  output  1  tx_data valid.
REQ-012 tx_eof  output  1  marks the last byte of a dump; valid only while tx_rdy=1.
REQ-013 tx_ack  input  1  arbiter accepts the byte; a transfer is tx_rdy=1 and tx_ack=1 in the same cycle.
REQ-014 busy  output  1  high while a dump is in progress.

Function
REQ-015 Shadow table: when register_rdy=1 and register_addr<NUM_REGS, the entry at register_addr SHALL take register_data at the next edge. Writes with addr>=NUM_REGS SHALL be ignored.
REQ-016 Dump format: 2*NUM_REGS bytes, entry 0 first; per entry, low byte (data[7:0]) then high byte (data[15:8]).
- REG_DATA_WIDTH<16: the high byte is zero-padded.
- REG_DATA_WIDTH>16: only bits [15:0] are sent.
REQ-017 FSM states are IDLE and SEND; byte counter width is log2(2*NUM_REGS).
REQ-018 IDLE -> SEND on rqst_readback=1 at edge n. At edge n the counter is cleared and byte 0 is loaded into tx_data, so tx_rdy=1 and busy=1 from cycle n+1 (one-cycle latency).
REQ-019 In SEND:
- tx_data and tx_eof SHALL stay stable while tx_ack=0.
- On a transfer, the counter increments and the next byte is registered, so a continuously high tx_ack yields one byte per cycle.
REQ-020 tx_eof SHALL be 1 exactly while the byte with index 2*NUM_REGS-1 is offered.
REQ-021 A transfer of the eof byte SHALL return the FSM to IDLE at that edge; tx_rdy, tx_eof and busy go 0 the next cycle.
REQ-022 rqst_readback while in SEND SHALL be ignored, including in the eof-transfer cycle.
REQ-023 A table write during SEND SHALL NOT alter the byte currently offered. Bytes not yet loaded SHALL reflect the written value.
REQ-024 A write to the entry whose byte is being loaded in the same cycle SHALL deliver the old value; the new value applies from the next load.
REQ-025 tx_ack while tx_rdy=0 SHALL have no effect.

Reset
REQ-026 With rst=1 at an edge, the following SHALL hold from the next cycle:
- FSM in IDLE, counter 0.
- tx_rdy=0, tx_eof=0, busy=0, tx_data=0.
- All shadow entries 0.
REQ-027 Reset SHALL take priority over register_rdy, rqst_readback and tx_ack in the same cycle, and SHALL abort a dump mid-stream with no further bytes and no eof.

Verification
REQ-028 After reset, pulse rqst_readback with tx_ack held 1 -> 32 bytes of 0x00 on consecutive cycles, tx_eof=1 only on byte 31, busy falls the cycle after.
REQ-029 Write addr 3=0xBEEF and addr 20=0x1234, then dump -> bytes 6,7 = 0xEF,0xBE; every other byte 0x00.
REQ-030 During a dump, hold tx_ack=0 for 5 cycles at byte 4 -> tx_data, tx_rdy and tx_eof unchanged for those cycles; the dump resumes at byte 5 when tx_ack returns to 1.
REQ-031 During a dump at byte 2, write addr 0=0x1111 and addr 9=0x2222 -> byte 0 already sent as 0x00; bytes 18,19 = 0x22,0x22.
REQ-032 Assert rst at byte 10 of a dump -> tx_rdy=0 next cycle, no eof; a following request dumps all zeros.
REQ-033 Pulse rqst_readback during SEND and in the eof-transfer cycle -> only one dump of 32 bytes total.

Source files
------------

// File: rtl/registers_tx_block.sv
// Shadows register-bus writes and streams the whole table out over a byte-wide tx port on request.
// Dump is low byte then high byte per entry; one byte per accepted tx transfer, one-cycle request latency.
module registers_tx_block #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int REG_DATA_WIDTH = 16,
  parameter int TX_DATA_WIDTH  = 8,
  parameter int NUM_REGS       = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] register_addr,
  input  logic [REG_DATA_WIDTH-1:0] register_data,
  input  logic                      register_rdy,
  input  logic                      rqst_readback,
  output logic [TX_DATA_WIDTH-1:0]  tx_data,
  output logic                      tx_rdy,
  output logic                      tx_eof,
  input  logic                      tx_ack,
  output logic                      busy
);

  localparam int IW = $clog2(NUM_REGS);
  localparam int CW = IW + 1;
  localparam int PW = (REG_DATA_WIDTH > 16) ? REG_DATA_WIDTH : 16;
  localparam logic [CW-1:0] LAST = CW'(2 * NUM_REGS - 1);
  localparam logic [REG_ADDR_WIDTH:0] NUM_REGS_A = (REG_ADDR_WIDTH + 1)'(NUM_REGS);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                    state;
  logic [REG_DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [CW-1:0]             cnt;
  logic [CW-1:0]             cnt_nxt;
  logic                      wr_en;

  assign wr_en   = register_rdy && ({1'b0, register_addr} < NUM_REGS_A);
  assign cnt_nxt = cnt + CW'(1);

  // Reads the pre-edge table contents, so a same-cycle write to the entry being
  // loaded is seen only on a later load.
  function automatic logic [TX_DATA_WIDTH-1:0] byte_of(input logic [CW-1:0] idx);
    logic [PW-1:0] wide;
    wide = PW'(regs[idx[CW-1:1]]);
    return TX_DATA_WIDTH'(idx[0] ? wide[15:8] : wide[7:0]);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      tx_data <= '0;
      tx_rdy  <= 1'b0;
      tx_eof  <= 1'b0;
      busy    <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        regs[register_addr[IW-1:0]] <= register_data;
      end
      case (state)
        IDLE: begin
          if (rqst_readback) begin
            state   <= SEND;
            cnt     <= '0;
            tx_data <= byte_of('0);
            tx_rdy  <= 1'b1;
            tx_eof  <= 1'b0;
            busy    <= 1'b1;
          end
        end
        SEND: begin
          if (tx_ack) begin
            if (tx_eof) begin
              state   <= IDLE;
              cnt     <= '0;
              tx_data <= '0;
              tx_rdy  <= 1'b0;
              tx_eof  <= 1'b0;
              busy    <= 1'b0;
            end else begin
              cnt     <= cnt_nxt;
              tx_data <= byte_of(cnt_nxt);
              tx_eof  <= (cnt_nxt == LAST);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_registers_tx_block.sv
// Directed bench for registers_tx_block: zero dump, table writes, stall, mid-dump writes,
// mid-dump reset and ignored requests, each byte checked against a hand-built expected table.
module tb_registers_tx_block;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  register_addr;
  logic [15:0] register_data;
  logic        register_rdy;
  logic        rqst_readback;
  logic [7:0]  tx_data;
  logic        tx_rdy;
  logic        tx_eof;
  logic        tx_ack;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [15:0] mdl   [16];
  logic [7:0]  exp_b [32];

  registers_tx_block dut (
    .clk           (clk),
    .rst           (rst),
    .register_addr (register_addr),
    .register_data (register_data),
    .register_rdy  (register_rdy),
    .rqst_readback (rqst_readback),
    .tx_data       (tx_data),
    .tx_rdy        (tx_rdy),
    .tx_eof        (tx_eof),
    .tx_ack        (tx_ack),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " tx_rdy"}, 32'(tx_rdy), 32'd0);
    chk({tag, " tx_eof"}, 32'(tx_eof), 32'd0);
    chk({tag, " busy"},   32'(busy),   32'd0);
  endtask

  task automatic fill_exp();
    for (int i = 0; i < 32; i++) begin
      exp_b[i] = i[0] ? mdl[i / 2][15:8] : mdl[i / 2][7:0];
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    register_addr = a;
    register_data = d;
    register_rdy  = 1'b1;
    tick();
    register_rdy  = 1'b0;
    if (a < 5'd16) mdl[a[3:0]] = d;
    chk($sformatf("write %0d no dump", a), 32'(tx_rdy), 32'd0);
  endtask

  task automatic chk_byte(input int i);
    chk($sformatf("byte%0d tx_rdy", i),  32'(tx_rdy),  32'd1);
    chk($sformatf("byte%0d busy", i),    32'(busy),    32'd1);
    chk($sformatf("byte%0d tx_data", i), 32'(tx_data), 32'(exp_b[i]));
    chk($sformatf("byte%0d tx_eof", i),  32'(tx_eof),  32'(i == 31));
  endtask

  // Negative arguments disable the corresponding event.
  task automatic dump(input int stall_at, input int wr_at, input int rst_at,
                      input int rq_a, input int rq_b);
    tx_ack        = 1'b1;
    rqst_readback = 1'b1;
    tick();
    rqst_readback = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i == stall_at) begin
        tx_ack = 1'b0;
        for (int s = 0; s < 5; s++) begin
          chk_byte(i);
          tick();
        end
        tx_ack = 1'b1;
      end
      chk_byte(i);
      if (i == rq_a || i == rq_b) rqst_readback = 1'b1;
      if (i == wr_at) begin
        register_rdy = 1'b1; register_addr = 5'd0; register_data = 16'h1111;
      end
      if (wr_at >= 0 && i == wr_at + 1) begin
        register_rdy = 1'b1; register_addr = 5'd9; register_data = 16'h2222;
      end
      if (i == rst_at) rst = 1'b1;
      tick();
      rqst_readback = 1'b0;
      register_rdy  = 1'b0;
      if (rst) begin
        rst = 1'b0;
        chk_idle("after abort");
        chk("after abort tx_data", 32'(tx_data), 32'd0);
        for (int k = 0; k < 16; k++) mdl[k] = 16'h0;
        return;
      end
    end
    chk_idle("after dump");
    tick();
    chk_idle("no second dump");
  endtask

  initial begin
    rst           = 1'b1;
    register_addr = '0;
    register_data = '0;
    register_rdy  = 1'b0;
    rqst_readback = 1'b0;
    tx_ack        = 1'b0;
    for (int k = 0; k < 16; k++) mdl[k] = 16'h0;
    tick();
    tick();
    rst = 1'b0;
    chk_idle("reset");
    chk("reset tx_data", 32'(tx_data), 32'd0);

    // ack while idle must not produce anything
    tx_ack = 1'b1;
    tick();
    chk_idle("ack idle");

    // all-zero dump; requests mid-stream and on the eof transfer are ignored
    fill_exp();
    dump(-1, -1, -1, 5, 31);

    // out-of-range address 20 is dropped; only entry 3 shows up as bytes 6,7
    wr(5'd3, 16'hBEEF);
    wr(5'd20, 16'h1234);
    fill_exp();
    chk("exp byte6", 32'(exp_b[6]), 32'hEF);
    chk("exp byte7", 32'(exp_b[7]), 32'hBE);
    dump(4, -1, -1, -1, -1);

    // writes at byte 2/3: entry 0 already sent as 0x00, entry 9 picked up later
    fill_exp();
    exp_b[18] = 8'h22;
    exp_b[19] = 8'h22;
    dump(-1, 2, -1, -1, -1);
    mdl[0] = 16'h1111;
    mdl[9] = 16'h2222;

    // reset aborts mid-stream and clears the table
    fill_exp();
    dump(-1, -1, 10, -1, -1);
    tick();
    chk_idle("post abort idle");
    fill_exp();
    dump(-1, -1, -1, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
